// File: rtl/suma_aritmetica_reg_pkg.sv
// ---------------------------------------------------------------------------
// suma_pkg
//   Shared widths and types for the registered calculator adder.
//   Also holds the binary-to-BCD helper used when the optional decimal
//   output (macro SUMA_BCD_SALIDA_EN) is built in.
// ---------------------------------------------------------------------------
package suma_pkg;

  localparam int ANCHO_OPER = 12;
  localparam int ANCHO_RES  = 13;

  typedef logic [ANCHO_OPER-1:0] operando_t;
  typedef logic [ANCHO_RES-1:0]  resultado_t;
  typedef logic [15:0]           bcd4_t;

  // Double-dabble (shift-add-3). The accumulator holds the four BCD digits
  // above the binary value. Before every shift, any digit >= 5 gets 3 added
  // so that the shift carries correctly into the next decimal digit.
  function automatic bcd4_t bin_a_bcd(input resultado_t bin);
    logic [ANCHO_RES+15:0] acc;
    acc = {16'd0, bin};
    for (int i = 0; i < ANCHO_RES; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (acc[ANCHO_RES+4*d +: 4] >= 4'd5) begin
          acc[ANCHO_RES+4*d +: 4] = acc[ANCHO_RES+4*d +: 4] + 4'd3;
        end
      end
      acc = acc << 1;
    end
    return acc[ANCHO_RES+15:ANCHO_RES];
  endfunction

endpackage

// File: rtl/suma_aritmetica_reg_if.sv
// ---------------------------------------------------------------------------
// suma_aritmetica_reg_if
//   Operand / result bundle of the registered adder.
//   num1, num2     : operands, driven by the operand-capture stage (master)
//   resultado      : registered sum with carry-out, driven by the adder (slave)
//   resultado_bcd  : 4 BCD digits of resultado, only with SUMA_BCD_SALIDA_EN
// ---------------------------------------------------------------------------
interface suma_aritmetica_reg_if #(
  parameter int ANCHO = 12
);

  logic [ANCHO-1:0] num1;
  logic [ANCHO-1:0] num2;
  logic [ANCHO:0]   resultado;
`ifdef SUMA_BCD_SALIDA_EN
  logic [15:0]      resultado_bcd;

  modport master (output num1, output num2, input  resultado, input  resultado_bcd);
  modport slave  (input  num1, input  num2, output resultado, output resultado_bcd);
`else
  modport master (output num1, output num2, input  resultado);
  modport slave  (input  num1, input  num2, output resultado);
`endif

endinterface

// File: rtl/suma_aritmetica_reg_sumador_completo.sv
// ---------------------------------------------------------------------------
// sumador_completo
//   One-bit full adder, the cell of the ripple-carry chain.
//   a, b  : operand bits
//   cin   : carry from the lower bit
//   s     : sum bit
//   cout  : carry to the upper bit
// ---------------------------------------------------------------------------
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/suma_aritmetica_reg.sv
// ---------------------------------------------------------------------------
// suma_aritmetica_reg
//   Registered unsigned adder for the calculator datapath. The sum of the
//   two operands (ripple-carry, carry-in 0) is registered every clock, so
//   resultado follows the operands with exactly one cycle of latency.
//
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, clears every output
//   bus.num1     operand A (unsigned)
//   bus.num2     operand B (unsigned)
//   bus.resultado  registered num1+num2, top bit is the carry-out
//
//   Optional build macro SUMA_BCD_SALIDA_EN adds bus.resultado_bcd: the
//   decimal digits {thousands,hundreds,tens,units} of resultado, registered
//   one cycle after resultado (two cycles after the operands).
// ---------------------------------------------------------------------------
import suma_pkg::*;

module suma_aritmetica_reg #(
  parameter int ANCHO = ANCHO_OPER
) (
  input  logic                 clk,
  input  logic                 rst,
  suma_aritmetica_reg_if.slave bus
);

  logic [ANCHO:0]   carry;
  logic [ANCHO-1:0] suma_bits;
  logic [ANCHO:0]   resultado_next;
  logic [ANCHO:0]   resultado_reg;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < ANCHO; gi++) begin : g_cadena
      sumador_completo u_fa (
        .a    (bus.num1[gi]),
        .b    (bus.num2[gi]),
        .cin  (carry[gi]),
        .s    (suma_bits[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Final carry becomes the MSB, so the sum never overflows.
  assign resultado_next = {carry[ANCHO], suma_bits};

  always_ff @(posedge clk) begin
    if (rst) begin
      resultado_reg <= '0;
    end else begin
      resultado_reg <= resultado_next;
    end
  end

  assign bus.resultado = resultado_reg;

`ifdef SUMA_BCD_SALIDA_EN
  // Converts the already registered sum, which keeps the double-dabble
  // network out of the adder's carry path at the cost of one extra cycle.
  bcd4_t bcd_next;
  bcd4_t bcd_reg;

  assign bcd_next = bin_a_bcd(resultado_t'(resultado_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg <= '0;
    end else begin
      bcd_reg <= bcd_next;
    end
  end

  assign bus.resultado_bcd = bcd_reg;
`endif

endmodule

// File: tb/tb_suma_aritmetica_reg.sv
`timescale 1ns/1ps
module tb_suma_aritmetica_reg;

  localparam int ANCHO = 12;

  logic clk;
  logic rst;

  suma_aritmetica_reg_if #(.ANCHO(ANCHO)) bus_if ();

  suma_aritmetica_reg #(.ANCHO(ANCHO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #18.5185 clk = ~clk;

  // Counters, touched only by the compare process.
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: plain integer arithmetic on the sampled inputs.
  int model_res = 0;
  int model_bcd = 0;
  bit model_valid = 0;

  function automatic int dec_a_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
           ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_bcd = 0;
      model_res = 0;
    end else begin
      model_bcd = dec_a_bcd(model_res);
      model_res = int'(bus_if.num1) + int'(bus_if.num2);
    end
    model_valid = 1;
  end

  // Hand-computed literal expectations, set by the stimulus for the next edge.
  bit lit_res_en = 0;
  int lit_res    = 0;
  bit lit_bcd_en = 0;
  int lit_bcd    = 0;
  int lit_id     = 0;

  // Single compare process: model check every cycle plus literal checks.
  always @(negedge clk) begin
    if (model_valid) begin
      n_cmp++;
      if (int'(bus_if.resultado) != model_res) begin
        n_bad++;
        $display("FAIL model_res t=%0t got=%0d exp=%0d", $time, bus_if.resultado, model_res);
      end
`ifdef SUMA_BCD_SALIDA_EN
      n_cmp++;
      if (int'(bus_if.resultado_bcd) != model_bcd) begin
        n_bad++;
        $display("FAIL model_bcd t=%0t got=%h exp=%h", $time, bus_if.resultado_bcd, model_bcd[15:0]);
      end
`endif
    end
    if (lit_res_en) begin
      n_cmp++;
      if (int'(bus_if.resultado) != lit_res) begin
        n_bad++;
        $display("FAIL lit_res#%0d got=%0d exp=%0d", lit_id, bus_if.resultado, lit_res);
      end else begin
        $display("step %0d resultado=%0d ok", lit_id, bus_if.resultado);
      end
    end
`ifdef SUMA_BCD_SALIDA_EN
    if (lit_bcd_en) begin
      n_cmp++;
      if (int'(bus_if.resultado_bcd) != lit_bcd) begin
        n_bad++;
        $display("FAIL lit_bcd#%0d got=%h exp=%h", lit_id, bus_if.resultado_bcd, lit_bcd[15:0]);
      end
    end
`endif
  end

  // Drive one vector just after a falling edge; the literal values are what
  // the outputs must show after the following rising edge.
  task automatic step(input bit r, input int a, input int b,
                      input int exp_res, input int exp_bcd);
    @(negedge clk);
    #1;
    rst          = r;
    bus_if.num1  = a[ANCHO-1:0];
    bus_if.num2  = b[ANCHO-1:0];
    lit_id       = lit_id + 1;
    lit_res_en   = 1;
    lit_res      = exp_res;
    lit_bcd_en   = 1;
    lit_bcd      = exp_bcd;
  endtask

  initial begin
    rst         = 1'b1;
    bus_if.num1 = '0;
    bus_if.num2 = '0;

    // Reset with zero operands.
    step(1, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    // Basic sums; the BCD column shows the previous sum's digits.
    step(0, 123, 456, 579, 16'h0000);
    step(0, 789, 987, 1776, 16'h0579);
    step(0, 999, 1, 1000, 16'h1776);
    step(0, 4095, 4095, 8190, 16'h1000);
    step(0, 4095, 1, 4096, 16'h8190);
    step(0, 0, 0, 0, 16'h4096);
    // Reset wins over live operands, then the first free edge captures them.
    step(1, 999, 1, 0, 16'h0000);
    step(0, 999, 1, 1000, 16'h0000);
    step(0, 999, 1, 1000, 16'h1000);
    // Operands change between edges: only the value at the edge counts.
    step(0, 5, 5, 15, 16'h1000);
    #5;
    bus_if.num1 = 12'd7;
    bus_if.num2 = 12'd8;
    step(0, 2048, 2048, 4096, 16'h0015);
    step(0, 1234, 4000, 5234, 16'h4096);
    step(0, 0, 4095, 4095, 16'h5234);
    step(0, 0, 0, 0, 16'h4095);

    @(negedge clk);
    #1;
    lit_res_en = 0;
    lit_bcd_en = 0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
